sobel_frame_ctrl: RTL

- Frame-level sequencer for the greyscale → line-buffer → 3x3 Sobel convolution datapath.
- Tracks pixel position from the DVAL/FVAL stream and decides when the 3x3 window is fully primed and valid.
- Latches the horizontal/vertical filter select only at frame start, so a switch toggle never tears a frame.
- Reports frame completion and stream errors; sits between the CCD capture stream and the convolution stage.

---
 rtl/sobel_ctrl_pkg.sv | 13 +
 rtl/sobel_pos_counter.sv | 47 ++++
 rtl/sobel_frame_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sobel_ctrl_pkg.sv
// Shared types and default geometry for the Sobel frame controller and the
// stream blocks that reuse its position counter.
package sobel_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} ctrl_state_t;

  typedef enum logic {FILT_VERT = 1'b0, FILT_HORZ = 1'b1} filt_mode_t;

  localparam int IMG_W_DEF = 1280;
  localparam int IMG_H_DEF = 960;
  localparam int CW_DEF    = 11;

endpackage

// File: rtl/sobel_pos_counter.sv
// Column/row wrap counter for a pixel stream. iCLR restarts at (0,0) and may
// coincide with iEN, in which case the restarted position is the one counted.
// oX/oY/oLAST describe the pixel presented this cycle (after any clear).
module sobel_pos_counter #(
  parameter int IMG_W = 1280,
  parameter int IMG_H = 960,
  parameter int CW    = 11
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iCLR,
  input  logic          iEN,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic          oLAST_COL,
  output logic          oLAST
);

  logic [CW-1:0] xReg;
  logic [CW-1:0] yReg;

  assign oX        = iCLR ? '0 : xReg;
  assign oY        = iCLR ? '0 : yReg;
  assign oLAST_COL = (oX == CW'(IMG_W - 1));
  assign oLAST     = oLAST_COL && (oY == CW'(IMG_H - 1));

  // Advance one position per enabled pixel, wrapping at the end of each line.
  // NOTE: state is written with <= so every register samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      xReg <= '0;
      yReg <= '0;
    end else if (iEN) begin
      if (oLAST_COL) begin
        xReg <= '0;
        yReg <= oY + CW'(1);
      end else begin
        xReg <= oX + CW'(1);
        yReg <= oY;
      end
    end else if (iCLR) begin
      xReg <= '0;
      yReg <= '0;
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the greyscale -> line buffer -> 3x3 Sobel datapath.
// Tracks pixel position, flags a primed non-border window, latches the filter
// select once per frame and reports frame completion and stream errors.
// Optional build macro SOBEL_FRAME_CTRL_STATS_EN adds frame/drop counters.
module sobel_frame_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iFVAL,
  input  logic          iDVAL,
  input  logic          iSW,
  output logic          oMODE,
  output logic          oPRIME,
  output logic          oWIN_VAL,
  output logic [CW-1:0] oCX,
  output logic [CW-1:0] oCY,
  output logic          oFRAME_DONE,
`ifdef SOBEL_FRAME_CTRL_STATS_EN
  output logic [15:0]   oFRAME_CNT,
  output logic [7:0]    oDROP_CNT,
`endif
  output logic          oERR
);

  ctrl_state_t   state;
  ctrl_state_t   nextState;
  filt_mode_t    modeReg;
  logic          fvalPrev;
  logic          fvalRise;
  logic          counted;
  logic          cntClr;
  logic          cntEn;
  logic          errSet;
  logic          doneSet;
  logic          dropSet;
  logic          latchMode;
  logic          winHit;
  logic [CW-1:0] posX;
  logic [CW-1:0] posY;
  logic          posLastCol;
  logic          posLast;

  assign fvalRise = iFVAL && !fvalPrev;
  assign counted  = iFVAL && iDVAL;
  assign winHit   = cntEn && (posX >= CW'(2)) && (posY >= CW'(2));
  assign oPRIME   = (state == PRIME);
  assign oMODE    = modeReg;

  sobel_pos_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .CW   (CW)
  ) uPos (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iCLR     (cntClr),
    .iEN      (cntEn),
    .oX       (posX),
    .oY       (posY),
    .oLAST_COL(posLastCol),
    .oLAST    (posLast)
  );

  // FSM state register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state and per-cycle control strobes.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    cntClr    = 1'b0;
    cntEn     = 1'b0;
    errSet    = 1'b0;
    doneSet   = 1'b0;
    dropSet   = 1'b0;
    latchMode = 1'b0;
    case (state)
      IDLE: begin
        if (fvalRise) begin
          latchMode = 1'b1;
          cntClr    = 1'b1;
          cntEn     = counted;
          nextState = PRIME;
        end
      end
      PRIME, RUN: begin
        if (!iFVAL) begin
          errSet    = 1'b1;
          dropSet   = 1'b1;
          nextState = IDLE;
        end else if (counted) begin
          cntEn = 1'b1;
          if (posLast) begin
            doneSet   = 1'b1;
            nextState = DONE;
          end else if (state == PRIME && posLastCol && posY == CW'(1)) begin
            nextState = RUN;
          end
        end
      end
      DONE: begin
        if (counted) errSet = 1'b1;
        if (!iFVAL)  nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Frame-level registers: edge detect, mode latch, window, done, error.
  // fvalPrev resets high so a frame already in flight at reset release is
  // ignored until iFVAL drops and rises again.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      fvalPrev    <= 1'b1;
      modeReg     <= FILT_VERT;
      oWIN_VAL    <= 1'b0;
      oCX         <= '0;
      oCY         <= '0;
      oFRAME_DONE <= 1'b0;
      oERR        <= 1'b0;
    end else begin
      fvalPrev    <= iFVAL;
      oWIN_VAL    <= winHit;
      oFRAME_DONE <= doneSet;
      if (latchMode) modeReg <= filt_mode_t'(iSW);
      if (winHit) begin
        oCX <= posX - CW'(1);
        oCY <= posY - CW'(1);
      end
      if (errSet) oERR <= 1'b1;
    end
  end

`ifdef SOBEL_FRAME_CTRL_STATS_EN
  // Completed-frame counter (wraps) and short-frame counter (saturates).
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oFRAME_CNT <= '0;
      oDROP_CNT  <= '0;
    end else begin
      if (doneSet) oFRAME_CNT <= oFRAME_CNT + 16'd1;
      if (dropSet && oDROP_CNT != 8'hFF) oDROP_CNT <= oDROP_CNT + 8'd1;
    end
  end
`endif

endmodule
